// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first with early exit.
// One bit pair per cycle; result flags held until the next accepted start.
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             agb,
   output logic             aeb,
   output logic             alb
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [IW-1:0]    idx;
   logic             gt;
   logic             eq;
   logic             lt;

   // Relations of the bit pair currently at the top of the shifters
   assign gt = sa[WIDTH-1] & ~sb[WIDTH-1];
   assign eq = ~(sa[WIDTH-1] ^ sb[WIDTH-1]);
   assign lt = ~sa[WIDTH-1] & sb[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         agb   <= 1'b0;
         aeb   <= 1'b0;
         alb   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  idx   <= IW'(WIDTH - 1);
                  agb   <= 1'b0;
                  aeb   <= 1'b0;
                  alb   <= 1'b0;
                  busy  <= 1'b1;
                  state <= CMP;
               end
            end
            CMP: begin
               unique case (1'b1)
                  gt: begin
                     agb   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end
                  lt: begin
                     alb   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end
                  eq: begin
                     if (idx == '0) begin
                        aeb   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        sa  <= sa << 1;
                        sb  <= sb << 1;
                        idx <= idx - IW'(1);
                     end
                  end
                  default: state <= CMP;
               endcase
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomised self-checking bench for serial_mag_comparator (WIDTH=8).
// Expected flags and latency come from plain arithmetic on the operands.
module tb_serial_mag_comparator;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         agb;
   logic         aeb;
   logic         alb;

   int n_cmp;
   int n_bad;

   serial_mag_comparator #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .agb   (agb),
      .aeb   (aeb),
      .alb   (alb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle in which done is expected, counting the start cycle as 0
   function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int j = 0; j < W; j++) begin
         if (x[W-1-j] != y[W-1-j]) return j + 2;
      end
      return W + 1;
   endfunction

   function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y);
      return {x > y, x == y, x < y};
   endfunction

   task automatic test_reset();
      logic [4:0] got;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      #1;
      got = {busy, done, agb, aeb, alb};
      n_cmp++;
      if (got !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want 00000", got);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      got = {busy, done, agb, aeb, alb};
      n_cmp++;
      if (got !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_release: got %b want 00000", got);
      end
   endtask

   task automatic test_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
      int         lat;
      logic [2:0] res;
      logic [2:0] want;
      lat = ref_latency(ta, tb_v);
      res = ref_flags(ta, tb_v);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL cmp_idle_busy a=%h b=%h: got %b want 0", ta, tb_v, busy);
      end
      a = ta;
      b = tb_v;
      start = 1'b1;
      for (int c = 1; c <= lat + 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         a = W'($urandom);
         b = W'($urandom);
         want = (c >= lat) ? res : 3'b000;
         n_cmp++;
         if (busy !== (c <= lat)) begin
            n_bad++;
            $display("FAIL cmp_busy a=%h b=%h cyc=%0d: got %b want %b",
                     ta, tb_v, c, busy, c <= lat);
         end
         n_cmp++;
         if (done !== (c == lat)) begin
            n_bad++;
            $display("FAIL cmp_done a=%h b=%h cyc=%0d: got %b want %b",
                     ta, tb_v, c, done, c == lat);
         end
         n_cmp++;
         if ({agb, aeb, alb} !== want) begin
            n_bad++;
            $display("FAIL cmp_flags a=%h b=%h cyc=%0d: got %b want %b",
                     ta, tb_v, c, {agb, aeb, alb}, want);
         end
      end
   endtask

   task automatic test_directed();
      test_compare(8'hA5, 8'h25);
      test_compare(8'h3C, 8'h3D);
      test_compare(8'h96, 8'h96);
      test_compare(8'h00, 8'h00);
      test_compare(8'hFF, 8'hFE);
      test_compare(8'h00, 8'h80);
   endtask

   task automatic test_random();
      logic [W-1:0] x;
      logic [W-1:0] y;
      for (int i = 0; i < 40; i++) begin
         x = W'($urandom);
         case (i % 4)
            0: y = x;
            1: y = x ^ W'(1 << $urandom_range(W - 1, 0));
            default: y = W'($urandom);
         endcase
         test_compare(x, y);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      int pulses;
      lat = ref_latency(8'h10, 8'h20);
      pulses = 0;
      @(negedge clk);
      a = 8'h10;
      b = 8'h20;
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = (c <= 2);
         a = (c <= 2) ? 8'hFF : a;
         if (done) pulses++;
         n_cmp++;
         if (done !== (c == lat)) begin
            n_bad++;
            $display("FAIL ignore_done cyc=%0d: got %b want %b", c, done, c == lat);
         end
         if (c == lat) begin
            n_cmp++;
            if ({agb, aeb, alb} !== 3'b001) begin
               n_bad++;
               $display("FAIL ignore_flags: got %b want 001", {agb, aeb, alb});
            end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (pulses != 1) begin
         n_bad++;
         $display("FAIL ignore_pulses: got %0d want 1", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int per;
      per = ref_latency(8'h80, 8'h00) + 1;
      @(negedge clk);
      a = 8'h80;
      b = 8'h00;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         n_cmp++;
         if (busy !== (k % per != 0)) begin
            n_bad++;
            $display("FAIL b2b_busy cyc=%0d: got %b want %b", k, busy, k % per != 0);
         end
         n_cmp++;
         if (done !== (k % per == per - 1)) begin
            n_bad++;
            $display("FAIL b2b_done cyc=%0d: got %b want %b", k, done, k % per == per - 1);
         end
         if (k % per == per - 1) begin
            n_cmp++;
            if ({agb, aeb, alb} !== 3'b100) begin
               n_bad++;
               $display("FAIL b2b_flags cyc=%0d: got %b want 100", k, {agb, aeb, alb});
            end
         end
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [4:0] got;
      @(negedge clk);
      a = 8'h3C;
      b = 8'h3D;
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      got = {busy, done, agb, aeb, alb};
      n_cmp++;
      if (got !== 5'b0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %b want 00000", got);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset_quiet cyc=%0d: got %b want 00", c, {busy, done});
         end
      end
      test_compare(8'h01, 8'h00);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be >= 1.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to capture a and b and begin a comparison.
REQ-005 Port: a  input  WIDTH  operand A, unsigned.
REQ-006 Port: b  input  WIDTH  operand B, unsigned.
REQ-007 Port: busy  output  1  high while a comparison is in progress or being reported.
REQ-008 Port: done  output  1  one-cycle pulse marking valid results.
REQ-009 Port: agb  output  1  A greater than B.
REQ-010 Port: aeb  output  1  A equal to B.
REQ-011 Port: alb  output  1  A less than B.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, CMP, DONE; all outputs registered.
REQ-013 IDLE: start=1 at a rising edge -> capture a and b into internal shift registers, set bit index to WIDTH-1, clear agb/aeb/alb to 0, go to CMP.
REQ-014 IDLE with start=0: hold state; agb/aeb/alb keep their last values.
REQ-015 CMP: each cycle SHALL evaluate exactly one bit pair, MSB first, using the per-bit relations gt = a_i & ~b_i, eq = ~(a_i ^ b_i), lt = ~a_i & b_i.
REQ-016 CMP, gt=1: register agb=1 and go to DONE; lt=1: register alb=1 and go to DONE (early termination).
REQ-017 CMP, eq=1 and index=0: register aeb=1 and go to DONE.
REQ-018 CMP, eq=1 and index>0: shift both registers left by one, decrement index, stay in CMP.
REQ-019 DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
REQ-020 busy SHALL be 1 in CMP and DONE, 0 in IDLE.
REQ-021 Latency: start sampled in cycle 0; with first differing bit at MSB-distance j (bit WIDTH-1-j), done=1 in cycle j+2; equal operands -> done=1 in cycle WIDTH+1.
REQ-022 At most one of agb/aeb/alb SHALL be 1 at any time; exactly one is 1 whenever done=1.
REQ-023 Results SHALL hold after done until the next accepted start clears them.
REQ-024 start while busy=1 SHALL be ignored (no queuing); changes on a/b after capture SHALL have no effect.
REQ-025 start held high continuously: a new capture occurs in each IDLE cycle, giving back-to-back operations separated by one IDLE cycle.
REQ-026 WIDTH=1: CMP always lasts one cycle; done in cycle 2.
REQ-027 Bit-index counter width SHALL be max(1, ceil(log2(WIDTH))); no wrap below 0.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE and busy=0, done=0, agb=0, aeb=0, alb=0; shift registers and index cleared.
REQ-029 Reset mid-operation SHALL abandon the comparison; no done pulse follows reset release.
REQ-030 After rst_n rises, the first start sampled on a clock edge SHALL be accepted normally.

Verification
REQ-031 WIDTH=8, a=8'hA5, b=8'h25, start in cycle 0 -> done=1, agb=1, aeb=0, alb=0 in cycle 2; busy=1 in cycles 1-2.
REQ-032 a=8'h3C, b=8'h3D -> done=1, alb=1 in cycle 9; agb=aeb=0 throughout.
REQ-033 a=b=8'h96 -> done=1, aeb=1 in cycle 9; aeb stays 1 in cycles 10+ until the next start.
REQ-034 a=8'h3C, b=8'h3D, start in cycle 0; rst_n=0 mid-cycle 4 -> busy/agb/aeb/alb=0 immediately; no done pulse; after release, start with a=8'h01, b=8'h00 -> agb=1, done in cycle 9 relative to that start.
REQ-035 a=8'h10, b=8'h20 started; start pulsed again in cycles 1 and 2 with a=8'hFF -> ignored; alb=1, done in cycle 4 only.
REQ-036 start held high for 12 cycles with a=8'h80, b=8'h00 -> done pulses in cycles 2, 5, 8, 11, each with agb=1; busy low in cycles 0, 3, 6, 9.
